// File: rtl/alu_iter_core.sv
// Multi-cycle ALU responder: single-cycle ADD/SUB and a shift-add iterative MUL,
// presented on a ready / result-valid handshake.
module alu_iter_core #(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_alu_a,
   input  logic [WIDTH-1:0] i_alu_b,
   input  logic [1:0]       i_alu_op,
   output logic             o_alu_ready,
   output logic             o_alu_res_valid,
   output logic [WIDTH-1:0] o_alu_result
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

   typedef enum logic [1:0] {INIT, IDLE, EXEC, MUL} state_e;

   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   addend;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= INIT;
         op_q     <= OP_NOP;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   // In MUL, a_q is the left-shifting multiplicand and b_q the right-shifting multiplier.
   assign addend = b_q[0] ? a_q : '0;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      valid_d  = valid_q;
      case (state_q)
         INIT: begin
            state_d = IDLE;
         end
         IDLE: begin
            if (i_alu_op != OP_NOP) begin
               a_d     = i_alu_a;
               b_d     = i_alu_b;
               op_d    = i_alu_op;
               acc_d   = '0;
               cnt_d   = '0;
               valid_d = 1'b0;
               state_d = (MUL_EN && (i_alu_op == OP_MUL)) ? MUL : EXEC;
            end
         end
         EXEC: begin
            case (op_q)
               OP_ADD:  result_d = a_q + b_q;
               OP_SUB:  result_d = a_q - b_q;
               default: result_d = '0;
            endcase
            valid_d = 1'b1;
            state_d = IDLE;
         end
         MUL: begin
            acc_d = acc_q + addend;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            // Last iteration folds its own partial product straight into the result.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               result_d = acc_q + addend;
               valid_d  = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   assign o_alu_ready     = (state_q == IDLE);
   assign o_alu_res_valid = valid_q;
   assign o_alu_result    = result_q;

endmodule

// File: tb/tb_alu_iter_core.sv
// Scoreboard bench for alu_iter_core: stimulus pushes expected results from a
// plain-arithmetic model, a monitor pops them on each result-valid rise.
module tb_alu_iter_core;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

   logic        clk;
   logic        rstN;
   logic [31:0] aI;
   logic [31:0] bI;
   logic [1:0]  opI;
   logic        readyO;
   logic        resValidO;
   logic [31:0] resultO;

   int          total = 0;
   int          bad = 0;
   logic [31:0] sb[$];
   logic        prevValid = 1'b0;

   alu_iter_core #(.WIDTH(32), .MUL_EN(1'b1)) dut (
      .i_clk           (clk),
      .i_rst_n         (rstN),
      .i_alu_a         (aI),
      .i_alu_b         (bI),
      .i_alu_op        (opI),
      .o_alu_ready     (readyO),
      .o_alu_res_valid (resValidO),
      .o_alu_result    (resultO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned prod;
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_MUL: begin
            prod = longint'(a) * longint'(b);
            return prod[31:0];
         end
         default: return 32'd0;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issues one op from a negedge with ready high, then counts busy cycles.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int expBusy, input bit scramble);
      int guard;
      int busy;
      guard = 0;
      while (!readyO && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("ready before issue", {31'd0, readyO}, 32'd1);
      opI = op;
      aI  = a;
      bI  = b;
      sb.push_back(refModel(op, a, b));
      @(negedge clk);
      opI  = OP_NOP;
      busy = 0;
      while (!readyO && busy < 100) begin
         busy++;
         if (scramble) begin
            aI  = $urandom;
            bI  = $urandom;
            opI = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
      end
      opI = OP_NOP;
      checkOutput("busy cycles", 32'(busy), 32'(expBusy));
   endtask

   // Monitor: compares each fresh result against the scoreboard head.
   always @(negedge clk) begin
      if (resValidO && !prevValid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected result: got 0x%08h expected none", resultO);
         end else begin
            checkOutput("result", resultO, sb.pop_front());
         end
      end
      if (resValidO) checkOutput("valid implies ready", {31'd0, readyO}, 32'd1);
      prevValid = resValidO;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int issued;
      int guard;
      rstN = 1'b0;
      opI  = OP_NOP;
      aI   = '0;
      bI   = '0;

      // Reset behaviour and the clean ready edge
      repeat (3) @(negedge clk);
      checkOutput("reset ready", {31'd0, readyO}, 32'd0);
      checkOutput("reset valid", {31'd0, resValidO}, 32'd0);
      checkOutput("reset result", resultO, 32'd0);
      rstN = 1'b1;
      #1;
      checkOutput("ready before first edge", {31'd0, readyO}, 32'd0);
      @(negedge clk);
      checkOutput("ready after init", {31'd0, readyO}, 32'd1);
      checkOutput("valid after init", {31'd0, resValidO}, 32'd0);

      // Wrapping ADD, then NOP hold
      applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 1, 1'b0);
      repeat (10) begin
         @(negedge clk);
         checkOutput("nop hold ready", {31'd0, readyO}, 32'd1);
         checkOutput("nop hold valid", {31'd0, resValidO}, 32'd1);
         checkOutput("nop hold result", resultO, 32'h0000_0001);
      end

      // Borrowing SUB and iterative MUL with scrambled inputs while busy
      applyStimulus(OP_SUB, 32'h0000_0003, 32'h0000_0005, 1, 1'b0);
      applyStimulus(OP_MUL, 32'h0001_0003, 32'h0000_0007, 32, 1'b1);
      applyStimulus(OP_MUL, $urandom, $urandom, 32, 1'b1);

      // Reset in the middle of a MUL
      opI = OP_MUL;
      aI  = $urandom;
      bI  = $urandom;
      @(negedge clk);
      opI = OP_NOP;
      repeat (9) @(negedge clk);
      rstN = 1'b0;
      #1;
      checkOutput("abort ready", {31'd0, readyO}, 32'd0);
      checkOutput("abort valid", {31'd0, resValidO}, 32'd0);
      checkOutput("abort result", resultO, 32'd0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("ready after abort", {31'd0, readyO}, 32'd1);
      applyStimulus(OP_ADD, 32'd2, 32'd3, 1, 1'b0);

      // Back-to-back ADD stream with op held
      issued = 0;
      guard  = 0;
      opI    = OP_ADD;
      while (issued < 32 && guard < 1000) begin
         if (readyO) begin
            aI = $urandom;
            bI = $urandom;
            sb.push_back(refModel(OP_ADD, aI, bI));
            issued++;
         end
         guard++;
         @(negedge clk);
      end
      guard = 0;
      while (!readyO && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      opI = OP_NOP;
      checkOutput("stream issued", 32'(issued), 32'd32);
      checkOutput("stream cycles", 32'(guard), 32'd1);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
